vdp_vram_arbiter: RTL and testbench

- Shares the single VDP VRAM port between three requesters: background tile fetch (fixed schedule), sprite fetch and CPU access (both req/ack).
- During active display, background owns 6 of every 8 pixel slots; slots 2 and 7 are free and go to sprite or CPU. During blanking, every slot is free.
- Sits between vdp_background, the sprite engine, the CPU port block and the VRAM BRAM. The BRAM has a synchronous, 1-cycle read.

---
 rtl/vdp_pkg.sv | 16 +
 rtl/vdp_rr_arb2.sv | 30 +++
 rtl/vdp_vram_arbiter.sv | 155 +++++++++++++++
 tb/tb_vdp_vram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vdp_pkg.sv
// Shared types and constants for the VDP VRAM arbiter and its round-robin helper.
package vdp_pkg;

  localparam int VRAM_AW = 14;

  localparam logic [2:0] SLOT_FREE_A = 3'd2;
  localparam logic [2:0] SLOT_FREE_B = 3'd7;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_BG   = 2'd1,
    OWN_SPR  = 2'd2,
    OWN_CPU  = 2'd3
  } owner_t;

endpackage

// File: rtl/vdp_rr_arb2.sv
// Two-requester arbiter: round-robin when rr_en is high, fixed A-first otherwise;
// force_b hands the grant to B whenever B requests.
module vdp_rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic rr_en,
  input  logic force_b,
  output logic gnt_a,
  output logic gnt_b
);

  logic ptr_b_reg;  // 1 = B holds round-robin priority
  logic prefer_b;

  assign prefer_b = force_b || (rr_en && ptr_b_reg);
  assign gnt_b    = req_b && (prefer_b || !req_a);
  assign gnt_a    = req_a && !gnt_b;

  // The pointer only moves on a contested round-robin decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_b_reg <= 1'b0;
    end else if (rr_en && req_a && req_b) begin
      ptr_b_reg <= gnt_a;
    end
  end

endmodule

// File: rtl/vdp_vram_arbiter.sv
// Shares the single VRAM port between background (fixed slots), sprite and CPU (req/ack).
// Optional: define VDP_CPU_STARVE_GUARD_EN to force a CPU grant after STARVE_MAX sprite wins.
module vdp_vram_arbiter
  import vdp_pkg::*;
#(
  parameter int H_ACTIVE = 256,
  parameter int V_ACTIVE = 192
`ifdef VDP_CPU_STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         pixel_x,
  input  logic [9:0]         pixel_y,
  input  logic [VRAM_AW-1:0] bg_addr,
  output logic [7:0]         bg_rdata,
  input  logic               spr_req,
  input  logic [VRAM_AW-1:0] spr_addr,
  output logic               spr_ack,
  output logic               spr_rvalid,
  output logic [7:0]         spr_rdata,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_addr,
  input  logic [7:0]         cpu_wdata,
  output logic               cpu_ack,
  output logic               cpu_rvalid,
  output logic [7:0]         cpu_rdata,
  output logic [VRAM_AW-1:0] vram_addr,
  output logic               vram_we,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);

  owner_t             owner_s1_reg, owner_s2_reg, owner_next;
  logic               rd_s1_reg, rd_s2_reg, rd_next;
  logic [VRAM_AW-1:0] addr_reg, addr_next;
  logic               we_reg, we_next;
  logic [7:0]         wdata_reg, wdata_next;

  logic       active, free_slot, ack_busy;
  logic       spr_elig, cpu_elig, spr_gnt, cpu_gnt, starve;
  logic [2:0] slot;
  logic [1:0] ack_vec, rvalid_vec;

  assign active    = (pixel_x < H_LIM) && (pixel_y < V_LIM);
  assign slot      = pixel_x[2:0];
  assign free_slot = !active || (slot == SLOT_FREE_A) || (slot == SLOT_FREE_B);

  // No sprite/CPU grant while an ack is visible, so a held req is never granted twice.
  assign ack_busy = spr_ack || cpu_ack;
  assign spr_elig = spr_req && free_slot && !ack_busy;
  assign cpu_elig = cpu_req && free_slot && !ack_busy;

`ifdef VDP_CPU_STARVE_GUARD_EN
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  logic [2:0] starve_cnt_reg;

  assign starve = active && (starve_cnt_reg >= STARVE_LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else if (!active || cpu_ack) begin
      starve_cnt_reg <= '0;
    end else if (spr_gnt && cpu_req && (starve_cnt_reg != 3'd7)) begin
      starve_cnt_reg <= starve_cnt_reg + 3'd1;
    end
  end
`else
  assign starve = 1'b0;
`endif

  vdp_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a   (spr_elig),
    .req_b   (cpu_elig),
    .rr_en   (!active),
    .force_b (starve),
    .gnt_a   (spr_gnt),
    .gnt_b   (cpu_gnt)
  );

  always_comb begin
    owner_next = OWN_NONE;
    rd_next    = 1'b0;
    addr_next  = '0;
    we_next    = 1'b0;
    wdata_next = '0;
    if (!free_slot) begin
      owner_next = OWN_BG;
      addr_next  = bg_addr;
    end else if (spr_gnt) begin
      owner_next = OWN_SPR;
      rd_next    = 1'b1;
      addr_next  = spr_addr;
    end else if (cpu_gnt) begin
      owner_next = OWN_CPU;
      rd_next    = !cpu_we;
      addr_next  = cpu_addr;
      we_next    = cpu_we;
      wdata_next = cpu_we ? cpu_wdata : 8'h00;
    end
  end

  // Stage 1 drives the VRAM port and acks; stage 2 lines up with the BRAM read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_s1_reg <= OWN_NONE;
      owner_s2_reg <= OWN_NONE;
      rd_s1_reg    <= 1'b0;
      rd_s2_reg    <= 1'b0;
      addr_reg     <= '0;
      we_reg       <= 1'b0;
      wdata_reg    <= '0;
    end else begin
      owner_s1_reg <= owner_next;
      owner_s2_reg <= owner_s1_reg;
      rd_s1_reg    <= rd_next;
      rd_s2_reg    <= rd_s1_reg;
      addr_reg     <= addr_next;
      we_reg       <= we_next;
      wdata_reg    <= wdata_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      localparam owner_t REQ_OWNER = (gi == 0) ? OWN_SPR : OWN_CPU;
      assign ack_vec[gi]    = (owner_s1_reg == REQ_OWNER);
      assign rvalid_vec[gi] = (owner_s2_reg == REQ_OWNER) && rd_s2_reg;
    end
  endgenerate

  assign spr_ack    = ack_vec[0];
  assign cpu_ack    = ack_vec[1];
  assign spr_rvalid = rvalid_vec[0];
  assign cpu_rvalid = rvalid_vec[1];
  assign spr_rdata  = spr_rvalid ? vram_rdata : 8'h00;
  assign cpu_rdata  = cpu_rvalid ? vram_rdata : 8'h00;
  assign bg_rdata   = vram_rdata;

  assign vram_addr  = addr_reg;
  assign vram_we    = we_reg;
  assign vram_wdata = wdata_reg;

endmodule

// File: tb/tb_vdp_vram_arbiter.sv
// Self-checking bench for vdp_vram_arbiter: transaction-level model plus directed literal checks.
module tb_vdp_vram_arbiter;

  localparam logic [1:0] O_NONE = 2'd0;
  localparam logic [1:0] O_BG   = 2'd1;
  localparam logic [1:0] O_SPR  = 2'd2;
  localparam logic [1:0] O_CPU  = 2'd3;

  logic        clk, rst;
  logic [9:0]  pixel_x, pixel_y;
  logic [13:0] bg_addr, spr_addr, cpu_addr, vram_addr;
  logic [7:0]  bg_rdata, spr_rdata, cpu_rdata, cpu_wdata, vram_wdata, vram_rdata;
  logic        spr_req, spr_ack, spr_rvalid;
  logic        cpu_req, cpu_we, cpu_ack, cpu_rvalid;
  logic        vram_we;

  vdp_vram_arbiter dut (
    .clk(clk), .rst(rst), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .bg_addr(bg_addr), .bg_rdata(bg_rdata),
    .spr_req(spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack),
    .spr_rvalid(spr_rvalid), .spr_rdata(spr_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
    .vram_rdata(vram_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  // VRAM BRAM: synchronous read, data one cycle after the address.
  logic [7:0] mem [16384];
  initial for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
  always @(posedge clk) begin
    if (vram_we) mem[vram_addr] <= vram_wdata;
    vram_rdata <= mem[vram_addr];
  end

  // Reference model: each decision becomes a transaction that shows on the port one
  // cycle later and returns data two cycles later.
  typedef struct packed {
    logic [1:0]  own;
    logic [13:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic [7:0]  rd;
  } txn_t;

  txn_t s1, s2, t;
  logic rr_cpu, m_act, m_free, m_busy, m_sr, m_cr, m_force, win_cpu;
  logic [7:0] ref_wr [int];
`ifdef VDP_CPU_STARVE_GUARD_EN
  int m_starve;
`endif

  function automatic logic [7:0] ref_rd(input logic [13:0] a);
    if (ref_wr.exists(int'(a))) return ref_wr[int'(a)];
    return pat(a);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 = '0;
      s2 = '0;
      rr_cpu = 1'b0;
`ifdef VDP_CPU_STARVE_GUARD_EN
      m_starve = 0;
`endif
    end else begin
      m_act  = (pixel_x < 10'd256) && (pixel_y < 10'd192);
      m_free = !m_act || (pixel_x[2:0] == 3'd2) || (pixel_x[2:0] == 3'd7);
      m_busy = (s1.own == O_SPR) || (s1.own == O_CPU);
      m_sr   = spr_req && m_free && !m_busy;
      m_cr   = cpu_req && m_free && !m_busy;
      m_force = 1'b0;
`ifdef VDP_CPU_STARVE_GUARD_EN
      m_force = m_act && (m_starve >= 4);
`endif
      t = '0;
      win_cpu = 1'b0;
      if (!m_free) begin
        t.own  = O_BG;
        t.addr = bg_addr;
        t.rd   = ref_rd(bg_addr);
      end else if (m_sr || m_cr) begin
        if (m_sr && m_cr) begin
          if (!m_act) begin
            win_cpu = rr_cpu;
            rr_cpu  = !rr_cpu;
          end else begin
            win_cpu = m_force;
          end
        end else begin
          win_cpu = m_cr;
        end
        if (win_cpu) begin
          t.own  = O_CPU;
          t.addr = cpu_addr;
          t.we   = cpu_we;
          if (cpu_we) begin
            t.wdata = cpu_wdata;
            ref_wr[int'(cpu_addr)] = cpu_wdata;
          end else begin
            t.rd = ref_rd(cpu_addr);
          end
        end else begin
          t.own  = O_SPR;
          t.addr = spr_addr;
          t.rd   = ref_rd(spr_addr);
        end
      end
`ifdef VDP_CPU_STARVE_GUARD_EN
      if (!m_act || (s1.own == O_CPU)) m_starve = 0;
      else if ((t.own == O_SPR) && cpu_req && (m_starve < 7)) m_starve = m_starve + 1;
`endif
      s2 = s1;
      s1 = t;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    if (rst) begin
      chk("rst_vram_addr", 32'(vram_addr), 32'd0);
      chk("rst_vram_we", 32'(vram_we), 32'd0);
      chk("rst_vram_wdata", 32'(vram_wdata), 32'd0);
      chk("rst_spr_ack", 32'(spr_ack), 32'd0);
      chk("rst_cpu_ack", 32'(cpu_ack), 32'd0);
      chk("rst_spr_rvalid", 32'(spr_rvalid), 32'd0);
      chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      chk("rst_spr_rdata", 32'(spr_rdata), 32'd0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
    end else begin
      chk("vram_addr", 32'(vram_addr), 32'(s1.addr));
      chk("vram_we", 32'(vram_we), 32'(s1.we));
      if (s1.we) chk("vram_wdata", 32'(vram_wdata), 32'(s1.wdata));
      chk("spr_ack", 32'(spr_ack), 32'(s1.own == O_SPR));
      chk("cpu_ack", 32'(cpu_ack), 32'(s1.own == O_CPU));
      chk("spr_rvalid", 32'(spr_rvalid), 32'(s2.own == O_SPR));
      chk("cpu_rvalid", 32'(cpu_rvalid), 32'((s2.own == O_CPU) && !s2.we));
      if (s2.own == O_SPR) chk("spr_rdata", 32'(spr_rdata), 32'(s2.rd));
      if ((s2.own == O_CPU) && !s2.we) chk("cpu_rdata", 32'(cpu_rdata), 32'(s2.rd));
      if (s2.own == O_BG) chk("bg_rdata", 32'(bg_rdata), 32'(s2.rd));
    end
  endtask

  // One clock: compare at the falling edge, return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    model_compare();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    spr_req = 1'b0;
    cpu_req = 1'b0;
    repeat (3) tick();
  endtask

  logic [15:0] seq;
  int n_spr_pre, n_cpu, n_we, n_ack;
  bit seen_cpu;

  initial begin
    rst = 1'b1;
    pixel_x = '0; pixel_y = '0; bg_addr = '0;
    spr_req = 1'b0; spr_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Active line, sprite held at 0x3F00 while x sweeps 0..15
    pixel_y = 10'd10;
    spr_req = 1'b1;
    spr_addr = 14'h3F00;
    for (int x = 0; x < 16; x++) begin
      pixel_x = 10'(x);
      bg_addr = 14'(32'h0100 + x);
      tick();
      chk("t1_spr_ack", 32'(spr_ack), 32'(x inside {2, 7, 10, 15}));
      chk("t1_spr_rvalid", 32'(spr_rvalid), 32'((x - 1) inside {2, 7, 10, 15}));
      if (spr_rvalid) chk("t1_spr_rdata", 32'(spr_rdata), 32'h3F);
      if (!((x % 8) inside {2, 7})) chk("t1_bg_addr", 32'(vram_addr), 32'(32'h0100 + x));
    end
    idle();

    // Idle free slot, then the right window edge
    pixel_x = 10'd2;
    tick();
    chk("t6_idle_addr", 32'(vram_addr), 32'd0);
    chk("t6_idle_we", 32'(vram_we), 32'd0);
    chk("t6_idle_ack", 32'({spr_ack, cpu_ack}), 32'd0);
    pixel_x = 10'd3;
    tick();
    chk("t6_idle_rvalid", 32'({spr_rvalid, cpu_rvalid}), 32'd0);
    spr_req = 1'b1;
    spr_addr = 14'h02A5;
    for (int x = 250; x < 259; x++) begin
      pixel_x = 10'(x);
      bg_addr = 14'(x);
      tick();
      if (x == 255) chk("t6_edge_ack_255", 32'(spr_ack), 32'd1);
    end
    idle();

    // Blanking, both held: SPR, -, CPU, -, ...
    pixel_y = 10'd200;
    pixel_x = 10'd0;
    spr_req = 1'b1; spr_addr = 14'h3F00;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0042;
    seq = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seq = {seq[13:0], spr_ack, cpu_ack};
    end
    chk("t2_rr_sequence", 32'(seq), 32'h8484);
    idle();

    // CPU write then read-back of 0x1234
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 14'h1234; cpu_wdata = 8'h5A;
    tick();
    chk("t3_we", 32'(vram_we), 32'd1);
    chk("t3_addr", 32'(vram_addr), 32'h1234);
    chk("t3_wdata", 32'(vram_wdata), 32'h5A);
    chk("t3_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    n_we = 0; n_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_we += int'(vram_we);
      n_ack += int'(cpu_ack);
    end
    chk("t3_we_single", 32'(n_we), 32'd0);
    chk("t3_ack_single", 32'(n_ack), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    chk("t3_rd_ack", 32'(cpu_ack), 32'd1);
    chk("t3_rd_rvalid_early", 32'(cpu_rvalid), 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("t3_rd_rvalid", 32'(cpu_rvalid), 32'd1);
    chk("t3_rd_data", 32'(cpu_rdata), 32'h5A);
    idle();

    // Active, both requesting: starvation behaviour
    pixel_y = 10'd20;
    spr_req = 1'b1; spr_addr = 14'h3F00;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h0042;
    n_spr_pre = 0; n_cpu = 0; seen_cpu = 1'b0;
    for (int x = 0; x < 40; x++) begin
      pixel_x = 10'(x);
      bg_addr = 14'(32'h0200 + x);
      tick();
      if (cpu_ack) begin
        n_cpu++;
        seen_cpu = 1'b1;
      end
      if (spr_ack && !seen_cpu) n_spr_pre++;
    end
`ifdef VDP_CPU_STARVE_GUARD_EN
    chk("t4_spr_before_cpu", 32'(n_spr_pre), 32'd4);
    chk("t4_cpu_grants", 32'(n_cpu), 32'd2);
`else
    chk("t4_spr_grants", 32'(n_spr_pre), 32'd10);
    chk("t4_cpu_grants", 32'(n_cpu), 32'd0);
`endif
    idle();

    // Reset between cpu_ack and cpu_rvalid
    pixel_y = 10'd200;
    pixel_x = 10'd0;
    spr_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    tick();
    chk("t5_pre_spr_ack", 32'(spr_ack), 32'd1);
    spr_req = 1'b0; cpu_req = 1'b0;
    repeat (2) tick();
    cpu_req = 1'b1;
    tick();
    chk("t5_cpu_ack", 32'(cpu_ack), 32'd1);
    cpu_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_ack", 32'({spr_ack, cpu_ack}), 32'd0);
    chk("t5_rst_addr", 32'(vram_addr), 32'd0);
    chk("t5_rst_we", 32'(vram_we), 32'd0);
    tick();
    chk("t5_rst_rvalid", 32'({spr_rvalid, cpu_rvalid}), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("t5_post_rvalid", 32'(cpu_rvalid), 32'd0);
    spr_req = 1'b1; cpu_req = 1'b1;
    tick();
    chk("t5_post_first_spr", 32'(spr_ack), 32'd1);
    chk("t5_post_first_cpu", 32'(cpu_ack), 32'd0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
